// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory port arbiter.
// Latency: none (types only).
// Backpressure: none (types only).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } arb_client_t;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter muxing instruction fetch and load/store onto one memory port.
// Latency: request to mem_* 1 cycle; mem_resp to client resp/rdata 1 cycle.
// Backpressure: clients hold requests until their resp pulse; one memory access in flight.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t  state_q;
    arb_state_t  state_d;
    arb_client_t last_grant_q;
    arb_client_t pick;
    logic        grant_vld;
    logic        i_req;
    logic        d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Next-state and grant selection; arbitration only ever happens in IDLE.
    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        pick      = CLI_I;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    // Tie: serve whichever client did not win last time.
                    pick = (last_grant_q == CLI_I) ? CLI_D : CLI_I;
                end else if (d_req) begin
                    pick = CLI_D;
                end else begin
                    pick = CLI_I;
                end
                grant_vld = i_req | d_req;
                if (grant_vld) begin
                    state_d = (pick == CLI_I) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= CLI_I;
        end else begin
            state_q <= state_d;
            if (grant_vld) begin
                last_grant_q <= pick;
            end
        end
    end

    // Registered memory request, response capture and client completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_resp      <= 1'b0;
            d_resp      <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            if (grant_vld) begin
                if (pick == CLI_I) begin
                    mem_address <= i_address;
                    mem_read    <= 1'b1;
                    mem_write   <= 1'b0;
                end else begin
                    mem_address <= d_address;
                    // A simultaneous read+write from the data side is resolved as a write.
                    mem_read    <= ~d_write;
                    mem_write   <= d_write;
                    if (d_write) begin
                        mem_wdata <= d_wdata;
                    end
                end
            end
            if (state_q == BUSY_I && mem_resp) begin
                i_rdata   <= mem_rdata;
                i_resp    <= 1'b1;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
            if (state_q == BUSY_D && mem_resp) begin
                // mem_read is still the in-flight direction; writes leave d_rdata alone.
                if (mem_read) begin
                    d_rdata <= mem_rdata;
                end
                d_resp    <= 1'b1;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a transaction scoreboard.
// Latency: n/a.
// Backpressure: bench plays memory with configurable response delay.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int errors = 0;
    int checks = 0;

    // Expected memory transactions in grant order; cli 0 = I, 1 = D.
    typedef struct {
        bit          cli;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } want_t;
    want_t want_q[$];

    // Reference copies of the client read-data registers.
    logic [31:0] i_m;
    logic [31:0] d_m;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit cli, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        want_t w;
        w.cli   = cli;
        w.wr    = wr;
        w.addr  = addr;
        w.wdata = wdata;
        want_q.push_back(w);
    endtask

    // Act as memory for one transaction: wait for the request, hold it for lat cycles,
    // respond with rd, then check the client completion against the scoreboard.
    task automatic serve(input int lat, input logic [31:0] rd, input bit drop,
                         input bit alt_en, input logic [31:0] alt_addr);
        want_t w;
        int n;
        n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", {63'd0, mem_read | mem_write}, 64'd1);
        chk("sb_nonempty", {63'd0, want_q.size() != 0}, 64'd1);
        if (!(mem_read || mem_write) || want_q.size() == 0) begin
            if (want_q.size() != 0) void'(want_q.pop_front());
            return;
        end
        w = want_q.pop_front();
        chk("mem_write", {63'd0, mem_write}, {63'd0, w.wr});
        chk("mem_read", {63'd0, mem_read}, {63'd0, !w.wr});
        chk("mem_address", {32'd0, mem_address}, {32'd0, w.addr});
        if (w.wr) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, w.wdata});
        for (int k = 1; k < lat; k++) begin
            if (alt_en && k == 1) d_address = alt_addr;
            @(negedge clk);
            chk("addr_hold", {32'd0, mem_address}, {32'd0, w.addr});
            chk("rw_hold", {62'd0, mem_read, mem_write}, {62'd0, !w.wr, w.wr});
        end
        mem_rdata = rd;
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
        if (!w.wr) begin
            if (w.cli == 1'b0) i_m = rd;
            else d_m = rd;
        end
        chk("i_resp", {63'd0, i_resp}, {63'd0, w.cli == 1'b0});
        chk("d_resp", {63'd0, d_resp}, {63'd0, w.cli == 1'b1});
        chk("i_rdata", {32'd0, i_rdata}, {32'd0, i_m});
        chk("d_rdata", {32'd0, d_rdata}, {32'd0, d_m});
        chk("mem_idle_in_done", {62'd0, mem_read, mem_write}, 64'd0);
        if (drop) begin
            if (w.cli == 1'b0) begin
                i_read = 1'b0;
            end else begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end
        @(negedge clk);
        chk("resp_pulse", {62'd0, i_resp, d_resp}, 64'd0);
        chk("no_grant_in_done", {62'd0, mem_read, mem_write}, 64'd0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
        i_m       = '0;
        d_m       = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
        chk("rst_mem_address", {32'd0, mem_address}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_i_rdata", {32'd0, i_rdata}, 64'd0);
        chk("rst_d_rdata", {32'd0, d_rdata}, 64'd0);
        chk("rst_resp", {62'd0, i_resp, d_resp}, 64'd0);

        // Single D write, memory responds two cycles after mem_write.
        d_write   = 1'b1;
        d_address = 32'h0000_0100;
        d_wdata   = 32'hDEAD_BEEF;
        push(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        serve(2, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0);

        // Single I read.
        i_read    = 1'b1;
        i_address = 32'h0000_0040;
        push(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        serve(1, 32'h00A0_0093, 1'b1, 1'b0, 32'h0);

        // Illegal read+write from the data side resolves to a write.
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'h0000_0200;
        d_wdata   = 32'h0000_1234;
        push(1'b1, 1'b1, 32'h0000_0200, 32'h0000_1234);
        @(negedge clk);
        serve(1, 32'h1111_2222, 1'b1, 1'b0, 32'h0);

        // Address stability: d_address changes while the read is in flight.
        d_read    = 1'b1;
        d_address = 32'h0000_0300;
        push(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        @(negedge clk);
        serve(3, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0000_03FC);

        // Reset while BUSY_D, then a stray mem_resp in IDLE.
        d_write   = 1'b1;
        d_address = 32'h0000_0400;
        d_wdata   = 32'h0000_0077;
        n = 0;
        @(negedge clk);
        while (!mem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_d_write", {63'd0, mem_write}, 64'd1);
        rst     = 1'b1;
        d_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        i_m = '0;
        d_m = '0;
        chk("midrst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
        chk("midrst_mem_address", {32'd0, mem_address}, 64'd0);
        chk("midrst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("midrst_i_rdata", {32'd0, i_rdata}, {32'd0, i_m});
        chk("midrst_d_rdata", {32'd0, d_rdata}, {32'd0, d_m});
        chk("midrst_resp", {62'd0, i_resp, d_resp}, 64'd0);
        mem_rdata = 32'h0000_0BAD;
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("stray_resp", {62'd0, i_resp, d_resp}, 64'd0);
        chk("stray_d_rdata", {32'd0, d_rdata}, 64'd0);
        @(negedge clk);
        chk("stray_resp_late", {62'd0, i_resp, d_resp}, 64'd0);
        chk("stray_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);

        // Tie after reset with both requests held: D, I, D, I.
        i_read    = 1'b1;
        i_address = 32'h0000_0080;
        d_read    = 1'b1;
        d_address = 32'h0000_0500;
        push(1'b1, 1'b0, 32'h0000_0500, 32'h0);
        push(1'b0, 1'b0, 32'h0000_0080, 32'h0);
        push(1'b1, 1'b0, 32'h0000_0500, 32'h0);
        push(1'b0, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk);
        serve(1, 32'hD000_0001, 1'b0, 1'b0, 32'h0);
        serve(2, 32'h1000_0002, 1'b0, 1'b0, 32'h0);
        serve(1, 32'hD000_0003, 1'b0, 1'b0, 32'h0);
        serve(1, 32'h1000_0004, 1'b1, 1'b0, 32'h0);
        d_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("quiet_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
        chk("quiet_resp", {62'd0, i_resp, d_resp}, 64'd0);
        chk("sb_drained", {32'd0, want_q.size()}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-client arbiter that multiplexes the instruction-fetch read port and the load/store unit's memory port onto a single physical memory interface. Sits directly downstream of the load/store top level, whose pmem_* port it consumes, and directly upstream of physical memory. It registers all outgoing memory signals and returns read data and a one-cycle response to whichever client was served. When both clients request in the same cycle, it alternates between them (round-robin).

## Interface
- ADDR_W, 32, address width of both clients and memory
- DATA_W, 32, data width of read and write data
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  instruction-side read request; held until i_resp.
- i_address  in  ADDR_W  instruction-side address.
- i_rdata  out  DATA_W  instruction-side read data; valid while i_resp=1.
- i_resp  out  1  one-cycle instruction-side completion pulse.
- d_read  in  1  data-side read request (from LD_ST pmem_read); held until d_resp.
- d_write  in  1  data-side write request (from LD_ST pmem_write); held until d_resp.
- d_address  in  ADDR_W  data-side address.
- d_wdata  in  DATA_W  data-side write data.
- d_rdata  out  DATA_W  data-side read data (to LD_ST pmem_rdata); valid while d_resp=1.
- d_resp  out  1  one-cycle data-side completion pulse (to LD_ST pmem_resp).
- mem_read  out  1  physical memory read request; registered.
- mem_write  out  1  physical memory write request; registered.
- mem_address  out  ADDR_W  physical memory address; registered.
- mem_wdata  out  DATA_W  physical memory write data; registered.
- mem_rdata  in  DATA_W  physical memory read data; sampled when mem_resp=1.
- mem_resp  in  1  physical memory completion pulse.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, only i_read: go to BUSY_I.
- IDLE, only d_read or d_write: go to BUSY_D.
- IDLE, both clients requesting: grant the client not recorded in last_grant, then update last_grant.
- last_grant resets to I, so the first tie after reset goes to D.
- On grant:
  - Latch the client's address into mem_address.
  - For a D write, also latch d_wdata into mem_wdata.
  - Assert mem_read (I, or D read) or mem_write (D write) from the next cycle.
- d_read and d_write both high is illegal. The arbiter treats it as a write.
- BUSY_x:
  - Hold all mem_* outputs stable until mem_resp.
  - On mem_resp, capture mem_rdata into the granted client's rdata register (reads only; d_rdata is not updated on writes).
  - On mem_resp, deassert mem_read/mem_write and go to DONE.
- DONE:
  - Assert the granted client's resp for exactly one cycle.
  - Go to IDLE; no arbitration happens in DONE.
  - Served client must drop or change its request in the cycle after resp.
- mem_resp while in IDLE or DONE is ignored.
- Client address and data changes after grant have no effect on the in-flight transaction.
- Reset values:
  - All outputs (mem_*, i_rdata, d_rdata, i_resp, d_resp) are 0.
  - state is IDLE; last_grant is I.
- Reset mid-transaction abandons the outstanding memory access; the memory model must be reset at the same time.

## Timing
- Request seen in IDLE at cycle 0 → mem_read/mem_write high at cycle 1.
- mem_resp at cycle k → client resp and rdata at cycle k+1 → IDLE at k+2.
- Earliest next grant is seen at k+2, with mem_* asserted at k+3.
- Minimum client latency is 3 cycles (memory responds in the cycle after the request), giving a minimum turnaround of 4 cycles per transaction.
- Only one memory transaction is outstanding at a time.
- Under continuous contention, I and D alternate strictly.

## Structure
- A shared package (mem_arb_pkg, imported alongside rv_structs) holds:
  - arb_state_t enum: IDLE, BUSY_I, BUSY_D, DONE.
  - arb_client_t enum: CLI_I, CLI_D.
- No sub-module. The two-way round-robin pick is inline combinational logic feeding the IDLE transition.
- Instantiated next to LD_ST_top: its pmem_* ports connect to d_*, and the fetch unit connects to i_*.

## Test plan
- Single D write:
  - Stimulus: d_write=1, d_address=0x0000_0100, d_wdata=0xDEADBEEF; memory responds 2 cycles after mem_write.
  - Response: mem_write=1 with that address and data from cycle 1; d_resp pulses once; d_rdata unchanged (0).
- Single I read:
  - Stimulus: i_read=1, i_address=0x0000_0040; memory returns 0x00A00093.
  - Response: i_rdata=0x00A00093 with i_resp for exactly one cycle; d_resp stays 0.
- Tie after reset:
  - Stimulus: i_read and d_read asserted together and held.
  - Response: D served first, then I, then D, then I; no grant is issued in any DONE cycle.
- Illegal d_read+d_write:
  - Stimulus: both high.
  - Response: mem_write=1, mem_read=0.
- Reset while BUSY_D:
  - Stimulus: rst=1 for one cycle while in BUSY_D.
  - Response: all outputs 0 the next cycle; a later stray mem_resp in IDLE produces no resp pulse.
- Address stability:
  - Stimulus: change d_address while in BUSY_D.
  - Response: mem_address holds the originally latched value until mem_resp.
